// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding, load-use and data-memory stalls,
// branch flushes, memory-wait timeout and a saturating stalled-cycle counter.
module hazard_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs1D,
   input  logic [4:0] rs2D,
   input  logic [4:0] rs1E,
   input  logic [4:0] rs2E,
   input  logic [4:0] rdE,
   input  logic [1:0] ResultsrcE,
   input  logic       PCSrcE,
   input  logic [4:0] rdM,
   input  logic       RegWriteM,
   input  logic [4:0] rdW,
   input  logic       RegWriteW,
   input  logic       mem_req_M,
   input  logic       mem_ready,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       mem_timeout,
   output logic [15:0] stall_cycles
);

   // state   | meaning
   // IDLE    | no outstanding data-memory wait
   // WAIT    | memory access pending, pipeline frozen
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_timeout_q, mem_timeout_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic        lw_stall;
   logic        mem_stall;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;

   assign lw_stall  = (ResultsrcE == 2'b01) && (rdE != 5'd0) &&
                      ((rdE == rs1D) || (rdE == rs2D));
   assign mem_stall = mem_req_M && !mem_ready;

   always_comb begin
      fwd_a = 2'b00;
      if (RegWriteM && (rdM != 5'd0) && (rdM == rs1E))      fwd_a = 2'b10;
      else if (RegWriteW && (rdW != 5'd0) && (rdW == rs1E)) fwd_a = 2'b01;
      fwd_b = 2'b00;
      if (RegWriteM && (rdM != 5'd0) && (rdM == rs2E))      fwd_b = 2'b10;
      else if (RegWriteW && (rdW != 5'd0) && (rdW == rs2E)) fwd_b = 2'b01;
   end

   // A memory stall freezes everything and defers branch/load-use flushes.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!reset) begin
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
         end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
            FlushW = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mem_stall) state_d = ST_WAIT;
         ST_WAIT: if (mem_ready || !mem_req_M) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      wait_cnt_d = wait_cnt_q;
      if (state_d == ST_IDLE)
         wait_cnt_d = 8'd0;
      else if ((state_q == ST_WAIT) && mem_stall && (wait_cnt_q != 8'hFF))
         wait_cnt_d = wait_cnt_q + 8'd1;

      mem_timeout_d = mem_timeout_q || ((wait_cnt_q == 8'hFF) && mem_stall);

      stall_cycles_d = stall_cycles_q;
      if ((lw_stall || mem_stall) && (stall_cycles_q != 16'hFFFF))
         stall_cycles_d = stall_cycles_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         wait_cnt_q     <= 8'd0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a cycle model pushes expected outputs each
// cycle, they are popped and compared against the DUT on the falling edge.
module tb_hazard_unit;

   logic       clk;
   logic       reset;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic [1:0] ResultsrcE;
   logic       PCSrcE, RegWriteM, RegWriteW, mem_req_M, mem_ready;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       mem_timeout;
   logic [15:0] stall_cycles;

   typedef struct packed {
      logic [6:0]  ctl;
      logic [3:0]  fwd;
      logic        tmo;
      logic [15:0] scnt;
      logic        st;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_bad = 0;

   logic        m_st;
   logic [7:0]  m_cnt;
   logic        m_tmo;
   logic [15:0] m_scnt;

   hazard_unit dut (
      .clk(clk), .reset(reset),
      .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
      .rdE(rdE), .ResultsrcE(ResultsrcE), .PCSrcE(PCSrcE),
      .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW),
      .mem_req_M(mem_req_M), .mem_ready(mem_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
      if (RegWriteM && rdM != 0 && rdM == rs)      return 2'b10;
      else if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
      else                                          return 2'b00;
   endfunction

   task automatic idle_inputs();
      reset = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
      ResultsrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
      mem_req_M = 0; mem_ready = 0;
   endtask

   // One cycle: predict, compare on the falling edge, advance model on the rising edge.
   task automatic step();
      exp_t e, g;
      logic ms, lw, nst;
      ms = mem_req_M && !mem_ready;
      lw = (ResultsrcE == 2'b01) && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      if (reset) begin
         e.ctl = 7'b0000111;
         e.fwd = 4'b0000;
      end else begin
         e.ctl = ms ? 7'b1111001 : {lw, lw, 1'b0, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
         e.fwd = {fwd_exp(rs1E), fwd_exp(rs2E)};
      end
      e.tmo  = m_tmo;
      e.scnt = m_scnt;
      e.st   = m_st;
      sb_q.push_back(e);

      @(negedge clk);
      g = sb_q.pop_front();
      chk("ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, g.ctl});
      chk("fwd", {28'd0, ForwardAE, ForwardBE}, {28'd0, g.fwd});
      chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, g.tmo});
      chk("stall_cycles", {16'd0, stall_cycles}, {16'd0, g.scnt});
      chk("fsm", {31'd0, dut.state_q}, {31'd0, g.st});

      @(posedge clk);
      if (reset) begin
         m_st = 0; m_cnt = 0; m_tmo = 0; m_scnt = 0;
      end else begin
         if ((ms || lw) && m_scnt != 16'hFFFF) m_scnt = m_scnt + 1;
         if (m_cnt == 8'hFF && ms) m_tmo = 1;
         nst = (m_st == 0) ? ms : !(mem_ready || !mem_req_M);
         if (!nst) m_cnt = 0;
         else if (m_st && ms && m_cnt != 8'hFF) m_cnt = m_cnt + 1;
         m_st = nst;
      end
      #1;
   endtask

   initial begin
      m_st = 0; m_cnt = 0; m_tmo = 0; m_scnt = 0;
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      step(); step();
      reset = 0;
      step();

      // Forwarding priority and x0
      rs1E = 5; RegWriteM = 1; rdM = 5; RegWriteW = 1; rdW = 5; step();
      chk("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
      RegWriteM = 0; step();
      chk("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
      rdW = 0; rs1E = 0; step();
      chk("fwdA_rf", {30'd0, ForwardAE}, 32'd0);
      rs2E = 9; rdM = 9; RegWriteM = 1; step();
      rdM = 0; rs2E = 0; RegWriteW = 1; rdW = 0; step();
      idle_inputs(); step();

      // Load-use stall, then x0 load-use must not stall
      ResultsrcE = 2'b01; rdE = 7; rs2D = 7; step();
      idle_inputs(); step();
      chk("lw_scnt", {16'd0, stall_cycles}, 32'd1);
      ResultsrcE = 2'b01; rdE = 0; rs1D = 0; step();
      idle_inputs(); step();

      // Three-cycle memory wait
      mem_req_M = 1; mem_ready = 0;
      repeat (3) step();
      mem_ready = 1; step();
      idle_inputs(); step();
      chk("mem3_scnt", {16'd0, stall_cycles}, 32'd4);

      // Branch deferred through a memory stall, and branch + load-use together
      mem_req_M = 1; mem_ready = 0; PCSrcE = 1;
      repeat (3) step();
      mem_ready = 1; step();
      idle_inputs(); PCSrcE = 1; ResultsrcE = 2'b01; rdE = 3; rs1D = 3; step();
      idle_inputs(); step();

      // Long wait: timeout is sticky and only reset clears it
      mem_req_M = 1; mem_ready = 0;
      repeat (300) step();
      chk("tmo_set", {31'd0, mem_timeout}, 32'd1);
      idle_inputs(); repeat (3) step();
      mem_req_M = 1; reset = 1; step();
      reset = 0; idle_inputs(); step();
      chk("tmo_clr", {31'd0, mem_timeout}, 32'd0);

      // Randomized mix
      for (int i = 0; i < 400; i++) begin
         rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
         rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
         rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
         rdW  = 5'($urandom_range(0, 3));
         ResultsrcE = 2'($urandom_range(0, 3));
         PCSrcE = 1'($urandom_range(0, 1));
         RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
         mem_req_M = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 31) == 0);
         step();
      end
      idle_inputs(); step();

      // Alternate load-use and memory stalls until the counter saturates
      for (int i = 0; i < 66000; i++) begin
         idle_inputs();
         if (i % 2 == 0) begin
            ResultsrcE = 2'b01; rdE = 4; rs1D = 4;
         end else begin
            mem_req_M = 1;
         end
         step();
      end
      idle_inputs(); step();
      chk("scnt_sat", {16'd0, stall_cycles}, 32'hFFFF);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
